adc_scan_sequencer: RTL

//  Multi-channel scan scheduler for the 8-bit SAR conversion controller (go/valid/result handshake).

---
 rtl/adc_scan_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan scheduler: walks the enabled ADC mux channels, settles, runs one SAR conversion (or four with ADC_AVG4_EN) and emits {channel, result}.
// Latency: SETTLE+12 cycles per channel start-to-handshake (plus 33 more with ADC_AVG4_EN), plus however long downstream holds off.
// Backpressure: a held result blocks the next SETTLE/conversion until res_ready; nothing is dropped. Optional macro: ADC_AVG4_EN.
module adc_scan_sequencer #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int SETTLE = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_enable,
    input  logic           i_start,
    input  logic           i_continuous,
    input  logic [NCH-1:0] i_ch_mask,
    output logic           o_adc_go,
    input  logic           i_adc_valid,
    input  logic [7:0]     i_adc_result,
    output logic [CHW-1:0] o_mux_sel,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic [CHW-1:0] o_res_ch,
    output logic [7:0]     o_res_data,
    output logic           o_busy,
    output logic           o_scan_done
);

    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_RELEASE,
        S_OUTPUT
    } state_t;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [NCH-1:0]   r_mask;
    logic [CHW-1:0]   r_mux_sel;
    logic             r_go;
    logic             r_res_valid;
    logic [CHW-1:0]   r_res_ch;
    logic [7:0]       r_res_data;
    logic             r_busy;
    logic             r_scan_done;

`ifdef ADC_AVG4_EN
    logic [9:0]       r_acc;
    logic [1:0]       r_conv_cnt;
    logic [9:0]       w_acc_sum;

    assign w_acc_sum = r_acc + {2'b00, i_adc_result};
`endif

    logic [CHW-1:0]   w_first_ch;
    logic [CHW-1:0]   w_next_ch;
    logic             w_next_any;

    // Lowest enabled channel of the live mask, used when a scan (re)starts
    always_comb begin
        w_first_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_first_ch = CHW'(i);
            end
        end
    end

    // Next enabled channel above the current one in the mask latched at scan start
    always_comb begin
        w_next_ch  = '0;
        w_next_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_mux_sel))) begin
                w_next_ch  = CHW'(i);
                w_next_any = 1'b1;
            end
        end
    end

    // Scan FSM with all outputs registered; enable low aborts from any state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_mux_sel   <= '0;
            r_go        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
`ifdef ADC_AVG4_EN
            r_acc       <= '0;
            r_conv_cnt  <= '0;
`endif
        end else begin
            r_scan_done <= 1'b0;
            if (!i_enable) begin
                // Abort drops any held result and never reports scan completion
                r_state     <= S_IDLE;
                r_go        <= 1'b0;
                r_res_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && (|i_ch_mask)) begin
                            r_mask    <= i_ch_mask;
                            r_mux_sel <= w_first_ch;
                            r_cnt     <= CNTW'(SETTLE - 1);
                            r_busy    <= 1'b1;
                            r_state   <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
`ifdef ADC_AVG4_EN
                        // SETTLE is only visited once per channel, so it doubles as channel entry
                        r_acc      <= '0;
                        r_conv_cnt <= '0;
`endif
                        if (r_cnt == '0) begin
                            r_go    <= 1'b1;
                            r_state <= S_CONVERT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_CONVERT: begin
                        if (i_adc_valid) begin
                            r_go     <= 1'b0;
                            r_res_ch <= r_mux_sel;
`ifdef ADC_AVG4_EN
                            r_acc <= w_acc_sum;
                            if (r_conv_cnt == 2'd3) begin
                                r_res_data <= w_acc_sum[9:2];
                            end
`else
                            r_res_data <= i_adc_result;
`endif
                            r_state <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        // go stays low here for one cycle so the controller drops back to wait
`ifdef ADC_AVG4_EN
                        if (r_conv_cnt == 2'd3) begin
                            r_res_valid <= 1'b1;
                            r_state     <= S_OUTPUT;
                        end else begin
                            r_conv_cnt <= r_conv_cnt + 2'd1;
                            r_go       <= 1'b1;
                            r_state    <= S_CONVERT;
                        end
`else
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
`endif
                    end
                    S_OUTPUT: begin
                        if (i_res_ready) begin
                            r_res_valid <= 1'b0;
                            if (w_next_any) begin
                                r_mux_sel <= w_next_ch;
                                r_cnt     <= CNTW'(SETTLE - 1);
                                r_state   <= S_SETTLE;
                            end else begin
                                r_scan_done <= 1'b1;
                                if (i_continuous && (|i_ch_mask)) begin
                                    r_mask    <= i_ch_mask;
                                    r_mux_sel <= w_first_ch;
                                    r_cnt     <= CNTW'(SETTLE - 1);
                                    r_state   <= S_SETTLE;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_adc_go    = r_go;
    assign o_mux_sel   = r_mux_sel;
    assign o_res_valid = r_res_valid;
    assign o_res_ch    = r_res_ch;
    assign o_res_data  = r_res_data;
    assign o_busy      = r_busy;
    assign o_scan_done = r_scan_done;

endmodule
